// File: rtl/bin_to_ssd_seq.sv
// rtl/bin_to_ssd_seq.sv - sequential double-dabble binary to seven-segment display driver
//
// Converts an unsigned BIN_WIDTH-bit value into DIGITS BCD digits, one input
// bit per clock, and drives DIGITS active-low seven-segment displays.
// Optional feature macro: BIN_TO_SSD_LZB_EN (leading-zero blanking).
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous active-high reset
//   start  - conversion request, sampled only while idle
//   bin    - unsigned input value, captured on the accepted start edge
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd/seg/ovf update
//   ovf    - last converted value exceeded 10^DIGITS-1
//   bcd    - packed BCD result, digit k in [4k+3:4k], digit 0 least significant
//   seg    - active-low segments, display k in [7k+6:7k], a=bit0 .. g=bit6
module bin_to_ssd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  // One spare nibble above the displayed digits catches values >= 10^DIGITS.
  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state, state_nx;
  logic [BIN_WIDTH-1:0] sreg, sreg_nx;
  logic [ACC_W-1:0]     acc, acc_nx, acc_adj;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 big, big_nx;
  logic                 busy_nx, done_nx, ovf_nx;
  logic [4*DIGITS-1:0]  bcd_nx;
  logic [7*DIGITS-1:0]  seg_nx, seg_calc;
  logic                 ovf_calc;

  // Add-3 correction on every nibble that would reach >= 10 after doubling.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  // When the input can exceed 10^(DIGITS+1)-1 the spare nibble itself wraps,
  // so the magnitude compare taken at capture keeps the flag exact.
  assign ovf_calc = big | (acc[ACC_W-1 -: 4] != 4'd0);

  always_comb begin
`ifdef BIN_TO_SSD_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_calc = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf_calc) begin
        seg_calc[7*k +: 7] = 7'h3F;
      end else begin
`ifdef BIN_TO_SSD_LZB_EN
        if (acc[4*k +: 4] != 4'd0 || k == 0) lead = 1'b0;
        seg_calc[7*k +: 7] = lead ? 7'h7F : enc(acc[4*k +: 4]);
`else
        seg_calc[7*k +: 7] = enc(acc[4*k +: 4]);
`endif
      end
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    acc_nx   = acc;
    cnt_nx   = cnt;
    big_nx   = big;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ovf_nx   = ovf;
    bcd_nx   = bcd;
    seg_nx   = seg;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nx  = bin;
          acc_nx   = '0;
          cnt_nx   = CNT_W'(BIN_WIDTH);
          big_nx   = (64'(bin) > MAX_VAL);
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        acc_nx  = {acc_adj[ACC_W-2:0], sreg[BIN_WIDTH-1]};
        sreg_nx = sreg << 1;
        cnt_nx  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = FINISH;
      end
      FINISH: begin
        bcd_nx   = acc[4*DIGITS-1:0];
        ovf_nx   = ovf_calc;
        seg_nx   = seg_calc;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      big   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      bcd   <= '0;
      seg   <= '1;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      big   <= big_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      ovf   <= ovf_nx;
      bcd   <= bcd_nx;
      seg   <= seg_nx;
    end
  end

endmodule

// File: tb/tb_bin_to_ssd_seq.sv
// tb/tb_bin_to_ssd_seq.sv - self-checking bench for bin_to_ssd_seq
module tb_bin_to_ssd_seq;

`ifdef BIN_TO_SSD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic [20:0] seg_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [13:0] seg_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [15:0] bin_c;
  logic [19:0] bcd_c;
  logic [34:0] seg_c;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bin_to_ssd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .seg(seg_a)
  );

  bin_to_ssd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .seg(seg_b)
  );

  bin_to_ssd_seq #(.BIN_WIDTH(16), .DIGITS(5)) u_c (
    .clock(clock), .reset(reset), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .bcd(bcd_c), .seg(seg_c)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [20:0] seg;
    logic [20:0] seg_lzb;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int which, input logic s, input logic [15:0] v);
    case (which)
      0: begin start_a = s; bin_a = v[7:0]; end
      1: begin start_b = s; bin_b = v[7:0]; end
      default: begin start_c = s; bin_c = v; end
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Single start pulse, then wait (bounded) for done; returns edges from the
  // start edge to the done sample and the number of busy-high samples.
  task automatic conv(input int which, input logic [15:0] v, output int cycles, output int busy_cnt);
    set_in(which, 1'b1, v);
    tick();
    busy_cnt = get_busy(which) ? 1 : 0;
    set_in(which, 1'b0, v);
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (get_done(which)) break;
      if (get_busy(which)) busy_cnt++;
    end
  endtask

  int cyc, bcnt, dones, first_t, diff;

  initial begin
    vecs[0] = '{8'd0,   12'h000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{8'd255, 12'h255, {7'h24, 7'h12, 7'h12}, {7'h24, 7'h12, 7'h12}};
    vecs[2] = '{8'd9,   12'h009, {7'h40, 7'h40, 7'h10}, {7'h7F, 7'h7F, 7'h10}};
    vecs[3] = '{8'd170, 12'h170, {7'h79, 7'h78, 7'h40}, {7'h79, 7'h78, 7'h40}};
    vecs[4] = '{8'd123, 12'h123, {7'h79, 7'h24, 7'h30}, {7'h79, 7'h24, 7'h30}};
    vecs[5] = '{8'd100, 12'h100, {7'h79, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40}};
    vecs[6] = '{8'd57,  12'h057, {7'h40, 7'h12, 7'h78}, {7'h7F, 7'h12, 7'h78}};

    reset = 1'b1;
    set_in(0, 1'b0, 16'd0);
    set_in(1, 1'b0, 16'd0);
    set_in(2, 1'b0, 16'd0);
    tick();
    tick();
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf",  64'(ovf_a),  64'd0);
    check("rst_bcd",  64'(bcd_a),  64'd0);
    check("rst_seg",  64'(seg_a),  64'h1FFFFF);
    check("rst_seg_c", 64'(seg_c), 64'h7FFFFFFFF);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      conv(0, 16'(vecs[i].bin), cyc, bcnt);
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd9);
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd9);
      check($sformatf("v%0d_bcd", i), 64'(bcd_a), 64'(vecs[i].bcd));
      check($sformatf("v%0d_seg", i), 64'(seg_a), LZB ? 64'(vecs[i].seg_lzb) : 64'(vecs[i].seg));
      check($sformatf("v%0d_ovf", i), 64'(ovf_a), 64'd0);
      tick();
      check($sformatf("v%0d_done_single", i), 64'(done_a), 64'd0);
    end

    // Starts while busy and in the finishing cycle are ignored.
    set_in(0, 1'b1, 16'd9);
    tick();
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      set_in(0, (k == 3 || k == 9), (k == 3 || k == 9) ? 16'd77 : 16'd9);
      tick();
      if (done_a) dones++;
    end
    check("ign_done_count", 64'(dones), 64'd1);
    check("ign_done_at_9", 64'(done_a), 64'd1);
    check("ign_busy_after", 64'(busy_a), 64'd0);
    check("ign_bcd", 64'(bcd_a), 64'h009);
    set_in(0, 1'b1, 16'd170);
    tick();
    check("restart_busy", 64'(busy_a), 64'd1);
    set_in(0, 1'b0, 16'd0);
    cyc = 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (done_a) break;
    end
    check("restart_latency", 64'(cyc), 64'd9);
    check("restart_bcd", 64'(bcd_a), 64'h170);
    tick();

    // Held start retriggers every BIN_WIDTH+2 cycles.
    set_in(0, 1'b1, 16'd42);
    first_t = -1;
    diff = 0;
    dones = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (done_a) begin
        dones++;
        if (first_t < 0) first_t = t;
        else if (dones == 2) diff = t - first_t;
      end
    end
    set_in(0, 1'b0, 16'd0);
    check("held_period", 64'(diff), 64'd10);
    check("held_bcd", 64'(bcd_a), 64'h042);
    for (int t = 0; t < 12; t++) tick();

    // Reset four cycles into a conversion aborts it.
    set_in(0, 1'b1, 16'd123);
    tick();
    set_in(0, 1'b0, 16'd123);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    check("abort_seg",  64'(seg_a),  64'h1FFFFF);
    check("abort_bcd",  64'(bcd_a),  64'd0);
    reset = 1'b0;
    dones = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (done_a) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    conv(0, 16'd123, cyc, bcnt);
    check("abort_rerun_bcd", 64'(bcd_a), 64'h123);
    tick();

    // DIGITS=2 overflow handling.
    conv(1, 16'd100, cyc, bcnt);
    check("d2_100_latency", 64'(cyc), 64'd9);
    check("d2_100_ovf", 64'(ovf_b), 64'd1);
    check("d2_100_seg", 64'(seg_b), 64'({7'h3F, 7'h3F}));
    check("d2_100_bcd", 64'(bcd_b), 64'h00);
    tick();
    conv(1, 16'd99, cyc, bcnt);
    check("d2_99_ovf", 64'(ovf_b), 64'd0);
    check("d2_99_bcd", 64'(bcd_b), 64'h99);
    check("d2_99_seg", 64'(seg_b), 64'({7'h10, 7'h10}));
    tick();
    conv(1, 16'd255, cyc, bcnt);
    check("d2_255_ovf", 64'(ovf_b), 64'd1);
    check("d2_255_bcd", 64'(bcd_b), 64'h55);
    check("d2_255_seg", 64'(seg_b), 64'({7'h3F, 7'h3F}));
    tick();

    // BIN_WIDTH=16, DIGITS=5.
    conv(2, 16'd65535, cyc, bcnt);
    check("w16_latency", 64'(cyc), 64'd17);
    check("w16_busy_cycles", 64'(bcnt), 64'd17);
    check("w16_bcd", 64'(bcd_c), 64'h65535);
    check("w16_ovf", 64'(ovf_c), 64'd0);
    check("w16_seg", 64'(seg_c), 64'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}));
    tick();
    conv(2, 16'd0, cyc, bcnt);
    check("w16_zero_bcd", 64'(bcd_c), 64'd0);
    check("w16_zero_seg", 64'(seg_c),
          LZB ? 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40})
              : 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
